// File: rtl/ysyx_24110015_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory port, one transaction in flight, with a response watchdog.
// The request path is combinational. The grant stays locked until the response handshake. Responses wait on the owner's resp_ready.
module ysyx_24110015_mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ifu_req_valid,
   output logic        o_ifu_req_ready,
   input  logic [31:0] i_ifu_addr,
   input  logic        i_ifu_wen,
   input  logic [31:0] i_ifu_wdata,
   input  logic [3:0]  i_ifu_wmask,
   output logic        o_ifu_resp_valid,
   input  logic        i_ifu_resp_ready,
   output logic [31:0] o_ifu_rdata,
   output logic        o_ifu_err,
   input  logic        i_lsu_req_valid,
   output logic        o_lsu_req_ready,
   input  logic [31:0] i_lsu_addr,
   input  logic        i_lsu_wen,
   input  logic [31:0] i_lsu_wdata,
   input  logic [3:0]  i_lsu_wmask,
   output logic        o_lsu_resp_valid,
   input  logic        i_lsu_resp_ready,
   output logic [31:0] o_lsu_rdata,
   output logic        o_lsu_err,
   output logic        o_s_req_valid,
   output logic [31:0] o_s_addr,
   output logic        o_s_wen,
   output logic [31:0] o_s_wdata,
   output logic [3:0]  o_s_wmask,
   input  logic        i_s_req_ready,
   input  logic        i_s_resp_valid,
   input  logic [31:0] i_s_rdata,
   input  logic        i_s_err,
   output logic        o_s_resp_ready,
   output logic        o_timeout_flag
);

   localparam int unsigned CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit WD_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_owner;
   logic          r_last;
   logic          r_wen;
   logic [CW-1:0] r_cnt;
   logic          r_timeout_flag;

   logic          w_any;
   logic          w_gnt;
   logic          w_sel;
   logic          w_fwd;
   logic          w_req_hs;
   logic          w_own_rready;
   logic          w_resp_hs;
   logic          w_expire;
   logic          w_rv;
   logic          w_re;
   logic [31:0]   w_rd;

   assign w_any = i_ifu_req_valid | i_lsu_req_valid;
   // A tie goes to whichever master was not granted last.
   assign w_gnt = (i_ifu_req_valid & i_lsu_req_valid) ? ~r_last : i_lsu_req_valid;
   assign w_sel = (r_state == S_IDLE) ? w_gnt : r_owner;
   assign w_fwd = i_rst & (((r_state == S_IDLE) & w_any) | (r_state == S_REQ));

   assign o_s_req_valid   = w_fwd & (w_sel ? i_lsu_req_valid : i_ifu_req_valid);
   assign o_s_addr        = w_fwd ? (w_sel ? i_lsu_addr  : i_ifu_addr)  : 32'h0;
   assign o_s_wen         = w_fwd & (w_sel ? i_lsu_wen : i_ifu_wen);
   assign o_s_wdata       = w_fwd ? (w_sel ? i_lsu_wdata : i_ifu_wdata) : 32'h0;
   assign o_s_wmask       = w_fwd ? (w_sel ? i_lsu_wmask : i_ifu_wmask) : 4'h0;
   assign o_ifu_req_ready = w_fwd & ~w_sel & i_s_req_ready;
   assign o_lsu_req_ready = w_fwd &  w_sel & i_s_req_ready;
   assign w_req_hs        = o_s_req_valid & i_s_req_ready;

   assign w_own_rready   = r_owner ? i_lsu_resp_ready : i_ifu_resp_ready;
   // Outside RESP any slave response is unsolicited or late, so it is drained.
   assign o_s_resp_ready = (r_state == S_RESP) ? w_own_rready : 1'b1;
   assign w_resp_hs      = (r_state == S_RESP) & i_s_resp_valid & w_own_rready;
   assign w_expire       = WD_EN & (r_state == S_RESP) & ~i_s_resp_valid & (r_cnt == TO_LAST);

   assign w_rv = ((r_state == S_RESP) & i_s_resp_valid) | (r_state == S_ERR);
   assign w_re = ((r_state == S_RESP) & i_s_resp_valid & i_s_err) | (r_state == S_ERR);
   assign w_rd = ((r_state == S_RESP) & i_s_resp_valid & ~i_s_err & ~r_wen) ? i_s_rdata : 32'h0;

   assign o_ifu_resp_valid = w_rv & ~r_owner;
   assign o_ifu_err        = w_re & ~r_owner;
   assign o_ifu_rdata      = r_owner ? 32'h0 : w_rd;
   assign o_lsu_resp_valid = w_rv & r_owner;
   assign o_lsu_err        = w_re & r_owner;
   assign o_lsu_rdata      = r_owner ? w_rd : 32'h0;
   assign o_timeout_flag   = r_timeout_flag;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_any) w_next = w_req_hs ? S_RESP : S_REQ;
         S_REQ:  if (w_req_hs) w_next = S_RESP;
         S_RESP: begin
            if (w_resp_hs)     w_next = S_IDLE;
            else if (w_expire) w_next = S_ERR;
         end
         S_ERR:  if (w_own_rready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state        <= S_IDLE;
         r_owner        <= 1'b0;
         r_last         <= 1'b0;
         r_wen          <= 1'b0;
         r_cnt          <= '0;
         r_timeout_flag <= 1'b0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_IDLE) && w_any) begin
            r_owner <= w_gnt;
            r_last  <= w_gnt;
         end
         // Remember the direction so write responses return zero data.
         if (w_req_hs) r_wen <= o_s_wen;
         if ((r_state != S_RESP) || w_resp_hs || w_expire) r_cnt <= '0;
         else if (!i_s_resp_valid)                         r_cnt <= r_cnt + CW'(1);
         if (w_expire) r_timeout_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Cycle-vector bench for the IFU/LSU memory arbiter; responses are checked against a queue filled as requests are issued.
module tb_ysyx_24110015_mem_arbiter;

   localparam logic [31:0] IA = 32'h8000_0000;
   localparam logic [31:0] LA = 32'h8000_0010;
   localparam logic [31:0] DC = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_wen, ifu_resp_valid, ifu_resp_ready, ifu_err;
   logic [31:0] ifu_addr, ifu_wdata, ifu_rdata;
   logic [3:0]  ifu_wmask;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        s_req_valid, s_wen, s_req_ready, s_resp_valid, s_err, s_resp_ready, timeout_flag;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wmask;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic iv, lv, srr, srv;
      logic [31:0] srd;
      logic se, irr, lrr;
      logic e_irq, e_lrq, e_srv;
      logic [31:0] e_sa;
      logic e_iv, e_lv, e_err;
      int   e_srr;
      int   pm;
      logic [31:0] pd;
      logic perr;
   } vec_t;

   typedef struct {
      logic m;
      logic [31:0] d;
      logic e;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];

   ysyx_24110015_mem_arbiter #(.TIMEOUT(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_ifu_req_valid(ifu_req_valid), .o_ifu_req_ready(ifu_req_ready),
      .i_ifu_addr(ifu_addr), .i_ifu_wen(ifu_wen), .i_ifu_wdata(ifu_wdata), .i_ifu_wmask(ifu_wmask),
      .o_ifu_resp_valid(ifu_resp_valid), .i_ifu_resp_ready(ifu_resp_ready),
      .o_ifu_rdata(ifu_rdata), .o_ifu_err(ifu_err),
      .i_lsu_req_valid(lsu_req_valid), .o_lsu_req_ready(lsu_req_ready),
      .i_lsu_addr(lsu_addr), .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
      .o_lsu_resp_valid(lsu_resp_valid), .i_lsu_resp_ready(lsu_resp_ready),
      .o_lsu_rdata(lsu_rdata), .o_lsu_err(lsu_err),
      .o_s_req_valid(s_req_valid), .o_s_addr(s_addr), .o_s_wen(s_wen),
      .o_s_wdata(s_wdata), .o_s_wmask(s_wmask), .i_s_req_ready(s_req_ready),
      .i_s_resp_valid(s_resp_valid), .i_s_rdata(s_rdata), .i_s_err(s_err),
      .o_s_resp_ready(s_resp_ready), .o_timeout_flag(timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void add(input int iv, input int lv, input int srr, input int srv,
                               input logic [31:0] srd, input int se, input int irr, input int lrr,
                               input int e_irq, input int e_lrq, input int e_srv, input logic [31:0] e_sa,
                               input int e_iv, input int e_lv, input int e_err, input int e_srr,
                               input int pm, input logic [31:0] pd, input int perr);
      vec_t v;
      v.iv = iv[0];  v.lv = lv[0];  v.srr = srr[0]; v.srv = srv[0]; v.srd = srd;
      v.se = se[0];  v.irr = irr[0]; v.lrr = lrr[0];
      v.e_irq = e_irq[0]; v.e_lrq = e_lrq[0]; v.e_srv = e_srv[0]; v.e_sa = e_sa;
      v.e_iv = e_iv[0]; v.e_lv = e_lv[0]; v.e_err = e_err[0]; v.e_srr = e_srr;
      v.pm = pm; v.pd = pd; v.perr = perr[0];
      vq.push_back(v);
   endfunction

   task automatic pop(input logic m);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected response on master %0d with nothing outstanding", m);
      end else begin
         e = sb.pop_front();
         chk1("sb_master", m, e.m);
         chk32("sb_rdata", m ? lsu_rdata : ifu_rdata, e.d);
         chk1("sb_err", m ? lsu_err : ifu_err, e.e);
      end
   endtask

   task automatic idle_inputs();
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = 32'h0; s_err = 1'b0;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
   endtask

   task automatic check_reset_outputs();
      chk1("rst_ifu_req_ready", ifu_req_ready, 1'b0);
      chk1("rst_lsu_req_ready", lsu_req_ready, 1'b0);
      chk1("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
      chk1("rst_s_req_valid", s_req_valid, 1'b0);
      chk1("rst_s_resp_ready", s_resp_ready, 1'b1);
      chk1("rst_timeout_flag", timeout_flag, 1'b0);
      chk32("rst_ifu_rdata", ifu_rdata, 32'h0);
   endtask

   // Asserts reset with requests pending so the outputs must be held off by reset itself.
   task automatic do_reset();
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; s_req_ready = 1'b1;
      rst = 1'b0;
      #3;
      check_reset_outputs();
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs();
      vec_t v;
      exp_t e;
      logic is_l;
      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         ifu_req_valid = v.iv; lsu_req_valid = v.lv; s_req_ready = v.srr;
         s_resp_valid = v.srv; s_rdata = v.srd; s_err = v.se;
         ifu_resp_ready = v.irr; lsu_resp_ready = v.lrr;
         if (v.pm != 0) begin
            e.m = (v.pm == 2); e.d = v.pd; e.e = v.perr;
            sb.push_back(e);
         end
         @(negedge clk);
         chk1("ifu_req_ready", ifu_req_ready, v.e_irq);
         chk1("lsu_req_ready", lsu_req_ready, v.e_lrq);
         chk1("s_req_valid", s_req_valid, v.e_srv);
         chk1("ifu_resp_valid", ifu_resp_valid, v.e_iv);
         chk1("lsu_resp_valid", lsu_resp_valid, v.e_lv);
         chk1("ifu_err", ifu_err, v.e_iv & v.e_err);
         chk1("lsu_err", lsu_err, v.e_lv & v.e_err);
         if (v.e_srr != 2) chk1("s_resp_ready", s_resp_ready, v.e_srr[0]);
         if (v.e_sa != DC) chk32("s_addr", s_addr, v.e_sa);
         if (!v.e_iv) chk32("ifu_rdata_idle", ifu_rdata, 32'h0);
         if (!v.e_lv) chk32("lsu_rdata_idle", lsu_rdata, 32'h0);
         if (v.e_srv) begin
            is_l = (v.e_sa == LA);
            chk1("s_wen", s_wen, is_l ? lsu_wen : ifu_wen);
            chk32("s_wdata", s_wdata, is_l ? lsu_wdata : ifu_wdata);
            chk32("s_wmask", {28'h0, s_wmask}, {28'h0, (is_l ? lsu_wmask : ifu_wmask)});
         end
         if (ifu_resp_valid && ifu_resp_ready) pop(1'b0);
         if (lsu_resp_valid && lsu_resp_ready) pop(1'b1);
         @(posedge clk);
         #1;
      end
      vq.delete();
   endtask

   initial begin
      ifu_addr = IA; ifu_wen = 1'b0; ifu_wdata = 32'h0; ifu_wmask = 4'h0;
      lsu_addr = LA; lsu_wen = 1'b0; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
      idle_inputs();
      do_reset();

      // IFU-only read: accepted with zero latency, data one cycle later, then IDLE.
      add(1,0,1,0,32'h0,0,1,1,            1,0,1,IA,  0,0,0,1, 1,32'h0000_0413,0);
      add(0,0,1,1,32'h0000_0413,0,1,1,    0,0,0,DC,  1,0,0,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,1,            0,0,0,32'h0, 0,0,0,1, 0,32'h0,0);
      run_vecs();

      // Round robin: first tie after reset goes to LSU, then alternation.
      do_reset();
      add(1,1,1,0,32'h0,0,1,1,            0,1,1,LA,  0,0,0,1, 2,32'h1111_2222,0);
      add(1,0,1,1,32'h1111_2222,0,1,1,    0,0,0,DC,  0,1,0,1, 0,32'h0,0);
      add(1,0,1,0,32'h0,0,1,1,            1,0,1,IA,  0,0,0,1, 1,32'h3333_4444,0);
      add(0,0,1,1,32'h3333_4444,0,0,1,    0,0,0,DC,  1,0,0,0, 0,32'h0,0);
      add(0,0,1,1,32'h3333_4444,0,1,1,    0,0,0,DC,  1,0,0,1, 0,32'h0,0);
      add(1,1,1,0,32'h0,0,1,1,            0,1,1,LA,  0,0,0,1, 2,32'h5555_6666,0);
      add(1,0,1,1,32'h5555_6666,0,1,1,    0,0,0,DC,  0,1,0,1, 0,32'h0,0);
      add(1,0,1,0,32'h0,0,1,1,            1,0,1,IA,  0,0,0,1, 1,32'h0,1);
      add(0,0,1,1,32'h7777_8888,1,1,1,    0,0,0,DC,  1,0,1,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,1,            0,0,0,32'h0, 0,0,0,1, 0,32'h0,0);
      run_vecs();

      // Slave stalls four cycles; LSU appears mid-wait and must not steal the grant. Then LSU write.
      lsu_wen = 1'b1;
      add(1,0,0,0,32'h0,0,1,1,            0,0,1,IA,  0,0,0,1, 1,32'h9999_AAAA,0);
      add(1,0,0,0,32'h0,0,1,1,            0,0,1,IA,  0,0,0,2, 0,32'h0,0);
      add(1,1,0,0,32'h0,0,1,1,            0,0,1,IA,  0,0,0,2, 0,32'h0,0);
      add(1,1,0,0,32'h0,0,1,1,            0,0,1,IA,  0,0,0,2, 0,32'h0,0);
      add(1,1,1,0,32'h0,0,1,1,            1,0,1,IA,  0,0,0,2, 0,32'h0,0);
      add(0,1,1,1,32'h9999_AAAA,0,1,1,    0,0,0,DC,  1,0,0,1, 0,32'h0,0);
      add(0,1,1,0,32'h0,0,1,1,            0,1,1,LA,  0,0,0,1, 2,32'h0,0);
      add(0,0,1,1,32'h0BAD_F00D,0,1,1,    0,0,0,DC,  0,1,0,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,1,            0,0,0,32'h0, 0,0,0,1, 0,32'h0,0);
      run_vecs();
      chk1("timeout_flag_clear", timeout_flag, 1'b0);

      // Watchdog: no response for 8 cycles after RESP entry, then a late response is dropped.
      lsu_wen = 1'b0;
      add(0,1,1,0,32'h0,0,1,1,            0,1,1,LA,  0,0,0,1, 2,32'h0,1);
      for (int k = 0; k < 8; k++)
         add(0,0,1,0,32'h0,0,1,1,         0,0,0,DC,  0,0,0,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,0,            0,0,0,DC,  0,1,1,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,1,            0,0,0,DC,  0,1,1,1, 0,32'h0,0);
      add(0,0,1,1,32'hFEED_FACE,0,1,1,    0,0,0,32'h0, 0,0,0,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,1,            0,0,0,32'h0, 0,0,0,1, 0,32'h0,0);
      run_vecs();
      chk1("timeout_flag_set", timeout_flag, 1'b1);

      // Reset in the middle of an IFU response, then a fresh IFU read.
      add(1,0,1,0,32'h0,0,1,1,            1,0,1,IA,  0,0,0,1, 0,32'h0,0);
      add(1,0,1,0,32'h0,0,1,1,            0,0,0,DC,  0,0,0,1, 0,32'h0,0);
      run_vecs();
      ifu_req_valid = 1'b1; s_req_ready = 1'b1;
      s_resp_valid = 1'b1; s_rdata = 32'h0000_AAAA;
      #1;
      chk1("pre_abort_ifu_resp_valid", ifu_resp_valid, 1'b1);
      rst = 1'b0;
      #1;
      check_reset_outputs();
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      add(1,0,1,0,32'h0,0,1,1,            1,0,1,IA,  0,0,0,1, 1,32'h1234_5678,0);
      add(0,0,1,1,32'h1234_5678,0,1,1,    0,0,0,DC,  1,0,0,1, 0,32'h0,0);
      add(0,0,1,0,32'h0,0,1,1,            0,0,0,32'h0, 0,0,0,1, 0,32'h0,0);
      run_vecs();

      chk32("sb_empty", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
